// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns one core load/store into a word-aligned,
// byte-enabled request/acknowledge bus access and stalls the core until done.
// Flags misaligned requests and bus timeouts; load data is returned
// right-justified and zero-filled.
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16,  // 0 disables the timeout
    parameter int unsigned CNT_W   = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_read,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StErr, StDone} state_t;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       acc_size;
    logic [1:0]       acc_off;

    logic             req_any;
    logic             misaligned;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata;
    logic [31:0]      rd_shifted;
    logic [31:0]      rd_aligned;
    logic             timeout_hit;

    // Decode the incoming request into lane enables, replicated data and alignment.
    always_comb begin
        req_any    = i_req_read | i_req_write;
        misaligned = 1'b0;
        req_be     = 4'b1111;
        req_wdata  = i_req_wdata;
        case (i_req_size)
            2'b00: begin
                req_be    = 4'b0001 << i_req_addr[1:0];
                req_wdata = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = i_req_addr[0];
                req_be     = i_req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata  = {2{i_req_wdata[15:0]}};
            end
            // Word and the reserved encoding both behave as a full word.
            default: begin
                misaligned = |i_req_addr[1:0];
            end
        endcase
        // Write wins when both request lines are high.
        if (!i_req_write) begin
            req_wdata = 32'h0;
        end
    end

    // Right-justify and zero-fill the returned word using the captured offset/size.
    always_comb begin
        rd_shifted = i_mem_rdata >> {acc_off, 3'b000};
        case (acc_size)
            2'b00:   rd_aligned = {24'h0, rd_shifted[7:0]};
            2'b01:   rd_aligned = {16'h0, rd_shifted[15:0]};
            default: rd_aligned = rd_shifted;
        endcase
        timeout_hit = (TIMEOUT != 32'd0) && (cnt == CntLast);
    end

    // Core stalls while a request is pending, being serviced, or being rejected.
    always_comb begin
        o_stall = ((state == StIdle) && req_any) || (state == StAccess) || (state == StErr);
    end

    // Transaction FSM with registered bus and result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= StIdle;
            cnt         <= '0;
            acc_size    <= 2'b00;
            acc_off     <= 2'b00;
            o_rdata     <= 32'h0;
            o_rvalid    <= 1'b0;
            o_misalign  <= 1'b0;
            o_bus_err   <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'h0;
            o_mem_be    <= 4'h0;
            o_mem_wdata <= 32'h0;
        end else begin
            o_rvalid   <= 1'b0;
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
            case (state)
                StIdle: begin
                    if (req_any) begin
                        if (misaligned) begin
                            state      <= StErr;
                            o_misalign <= 1'b1;
                        end else begin
                            state       <= StAccess;
                            cnt         <= '0;
                            acc_size    <= i_req_size;
                            acc_off     <= i_req_addr[1:0];
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_req_write;
                            o_mem_addr  <= {i_req_addr[31:2], 2'b00};
                            o_mem_be    <= req_be;
                            o_mem_wdata <= req_wdata;
                        end
                    end
                end
                StAccess: begin
                    // An ack in the final allowed cycle beats the timeout.
                    if (i_mem_ack) begin
                        state     <= StDone;
                        o_mem_req <= 1'b0;
                        o_rvalid  <= 1'b1;
                        o_rdata   <= o_mem_we ? 32'h0 : rd_aligned;
                    end else if (timeout_hit) begin
                        state     <= StDone;
                        o_mem_req <= 1'b0;
                        o_rvalid  <= 1'b1;
                        o_bus_err <= 1'b1;
                        o_rdata   <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StErr: begin
                    state   <= StDone;
                    o_rdata <= 32'h0;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: a transaction-level model predicts every
// output each cycle; a few literal expectations pin the model itself.
module tb_dmem_bus_ctrl;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        stall;
    logic [31:0] rdata;
    logic        rvalid;
    logic        misalign;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    dmem_bus_ctrl #(
        .TIMEOUT(TO),
        .CNT_W  (5)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_read (req_read),
        .i_req_write(req_write),
        .i_req_addr (req_addr),
        .i_req_wdata(req_wdata),
        .i_req_size (req_size),
        .o_stall    (stall),
        .o_rdata    (rdata),
        .o_rvalid   (rvalid),
        .o_misalign (misalign),
        .o_bus_err  (bus_err),
        .o_mem_req  (mem_req),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_be   (mem_be),
        .o_mem_wdata(mem_wdata),
        .i_mem_ack  (mem_ack),
        .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle, written by the driver.
    logic        check_en = 1'b0;
    logic        chk_bus  = 1'b0;
    logic        exp_stall, exp_rvalid, exp_misalign, exp_bus_err;
    logic        exp_mem_req, exp_mem_we;
    logic [31:0] exp_rdata, exp_mem_addr, exp_mem_wdata;
    logic [3:0]  exp_mem_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---- model: access size in bytes, lanes and data derived byte by byte ----
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic int first_lane(input logic [31:0] a, input logic [1:0] s);
        return (nbytes(s) == 4) ? 0 : int'(a % 4);
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] s);
        logic [3:0] r = 4'h0;
        for (int i = 0; i < nbytes(s); i++) r[first_lane(a, s) + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [1:0] s);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nbytes(s)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] word, input logic [31:0] a,
                                            input logic [1:0] s);
        logic [31:0] r = 32'h0;
        for (int j = 0; j < nbytes(s); j++) r[8*j +: 8] = word[8*(first_lane(a, s) + j) +: 8];
        return r;
    endfunction

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
            chk("misalign", 32'(misalign), 32'(exp_misalign));
            chk("bus_err", 32'(bus_err), 32'(exp_bus_err));
            chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
            chk("rdata", rdata, exp_rdata);
            if (exp_mem_req || chk_bus) begin
                chk("mem_we", 32'(mem_we), 32'(exp_mem_we));
                chk("mem_addr", mem_addr, exp_mem_addr);
                chk("mem_be", 32'(mem_be), 32'(exp_mem_be));
                chk("mem_wdata", mem_wdata, exp_mem_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_req();
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic clear_pulses();
        exp_stall    = 1'b0;
        exp_rvalid   = 1'b0;
        exp_misalign = 1'b0;
        exp_bus_err  = 1'b0;
        exp_mem_req  = 1'b0;
    endtask

    // One core transaction; ack_at is the bus cycle (1-based) carrying the ack, 0 for none.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size,
                          input logic [31:0] mword, input int ack_at,
                          input logic [3:0] lit_be, input logic [31:0] lit_wdata,
                          input logic [31:0] lit_rdata);
        int  n     = nbytes(size);
        int  k     = 1;
        bit  acked = 1'b0;
        req_read  = rd;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        clear_pulses();
        exp_stall = 1'b1;
        step();
        if ((addr % n) != 0) begin
            exp_misalign = 1'b1;
            step();
            drop_req();
            exp_misalign = 1'b0;
            exp_stall    = 1'b0;
            exp_rdata    = 32'h0;
            step();
        end else begin
            exp_mem_req   = 1'b1;
            exp_mem_we    = wr;
            exp_mem_addr  = {addr[31:2], 2'b00};
            exp_mem_be    = m_be(addr, size);
            exp_mem_wdata = wr ? m_wdata(wdata, size) : 32'h0;
            while (!acked && k <= int'(TO)) begin
                mem_ack   = (k == ack_at);
                mem_rdata = (k == ack_at) ? mword : $urandom();
                if (k == 1) begin
                    #2;
                    chk("lit_be", 32'(mem_be), 32'(lit_be));
                    chk("lit_wdata", mem_wdata, lit_wdata);
                end
                step();
                acked = (k == ack_at);
                k++;
            end
            mem_ack = 1'b0;
            drop_req();
            exp_mem_req = 1'b0;
            exp_stall   = 1'b0;
            exp_rvalid  = 1'b1;
            exp_bus_err = !acked;
            exp_rdata   = (!acked || wr) ? 32'h0 : m_rdata(mword, addr, size);
            #2;
            chk("lit_rdata", rdata, lit_rdata);
            step();
        end
        clear_pulses();
        step();
    endtask

    // Reset during an access: bus drops, a late ack is ignored, no completion.
    task automatic do_reset_mid();
        req_read  = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h300;
        req_wdata = 32'h0;
        req_size  = 2'b11;
        clear_pulses();
        exp_stall = 1'b1;
        step();
        exp_mem_req   = 1'b1;
        exp_mem_we    = 1'b0;
        exp_mem_addr  = 32'h300;
        exp_mem_be    = 4'hF;
        exp_mem_wdata = 32'h0;
        mem_ack       = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drop_req();
        clear_pulses();
        exp_rdata     = 32'h0;
        exp_mem_we    = 1'b0;
        exp_mem_addr  = 32'h0;
        exp_mem_be    = 4'h0;
        exp_mem_wdata = 32'h0;
        chk_bus       = 1'b1;
        step();
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555AAAA;
        step();
        mem_ack = 1'b0;
        step();
        chk_bus = 1'b0;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_size  = 2'b00;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        step();
        clear_pulses();
        exp_rdata     = 32'h0;
        exp_mem_we    = 1'b0;
        exp_mem_addr  = 32'h0;
        exp_mem_be    = 4'h0;
        exp_mem_wdata = 32'h0;
        chk_bus       = 1'b1;
        check_en      = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk_bus = 1'b0;

        //     rd    wr    addr        wdata         size   mword         ack be     lit_wdata     lit_rdata
        do_txn(1'b1, 1'b0, 32'h100, 32'h0,        2'b11, 32'hDEADBEEF, 1, 4'hF, 32'h0,        32'hDEADBEEF);
        do_txn(1'b1, 1'b0, 32'h103, 32'h0,        2'b00, 32'h80112233, 2, 4'h8, 32'h0,        32'h00000080);
        do_txn(1'b1, 1'b0, 32'h102, 32'h0,        2'b01, 32'h80112233, 1, 4'hC, 32'h0,        32'h00008011);
        do_txn(1'b1, 1'b0, 32'h101, 32'h0,        2'b00, 32'h80112233, 3, 4'h2, 32'h0,        32'h00000022);
        do_txn(1'b0, 1'b1, 32'h201, 32'h000000A5, 2'b00, 32'hFFFFFFFF, 1, 4'h2, 32'hA5A5A5A5, 32'h0);
        do_txn(1'b0, 1'b1, 32'h202, 32'h00001234, 2'b01, 32'hFFFFFFFF, 2, 4'hC, 32'h12341234, 32'h0);
        do_txn(1'b1, 1'b0, 32'h100, 32'h0,        2'b01, 32'hCAFEBABE, 1, 4'h3, 32'h0,        32'h0000BABE);
        do_txn(1'b1, 1'b0, 32'h102, 32'h0,        2'b11, 32'h0,        1, 4'h0, 32'h0,        32'h0);
        do_txn(1'b1, 1'b0, 32'h101, 32'h0,        2'b01, 32'h0,        1, 4'h0, 32'h0,        32'h0);
        do_txn(1'b1, 1'b0, 32'h103, 32'h0,        2'b10, 32'h0,        1, 4'h0, 32'h0,        32'h0);
        do_txn(1'b1, 1'b0, 32'h104, 32'h0,        2'b11, 32'h13572468, 1, 4'hF, 32'h0,        32'h13572468);
        do_txn(1'b1, 1'b0, 32'h400, 32'h0,        2'b11, 32'h0,        0, 4'hF, 32'h0,        32'h0);
        do_txn(1'b1, 1'b0, 32'h404, 32'h0,        2'b11, 32'hCAFEF00D, 4, 4'hF, 32'h0,        32'hCAFEF00D);
        do_txn(1'b1, 1'b1, 32'h500, 32'h11223344, 2'b11, 32'h99999999, 1, 4'hF, 32'h11223344, 32'h0);
        do_txn(1'b1, 1'b0, 32'h600, 32'h0,        2'b10, 32'h0BADF00D, 2, 4'hF, 32'h0,        32'h0BADF00D);
        do_reset_mid();
        do_txn(1'b1, 1'b0, 32'h102, 32'h0,        2'b00, 32'hA1B2C3D4, 1, 4'h4, 32'h0,        32'h000000B2);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
Data-memory bus controller directly downstream of the core's memory unit. It accepts one load/store request per transaction (address, size, write data), converts it to a word-aligned, byte-lane-enabled access on a request/acknowledge memory bus, and stalls the core until the access completes. Load data is returned right-justified and zero-filled; the memory unit applies sign extension. The block flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 16, max cycles to wait for i_mem_ack before aborting; 0 disables timeout
CNT_W, 5, width of timeout counter; must hold TIMEOUT

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  reset, synchronous, active-high
i_req_read  in  1  load request
i_req_write  in  1  store request; wins if both high
i_req_addr  in  32  byte address
i_req_wdata  in  32  store data, right-justified
i_req_size  in  2  00 byte, 01 half, 11 word, 10 reserved (treated as word)
o_stall  out  1  core must hold request inputs and pipeline
o_rdata  out  32  load data, right-justified, zero-filled
o_rvalid  out  1  one-cycle pulse: o_rdata valid / store done
o_misalign  out  1  one-cycle pulse: misaligned request rejected
o_bus_err  out  1  one-cycle pulse: access aborted by timeout
o_mem_req  out  1  bus request, held until ack
o_mem_we  out  1  1 write, 0 read
o_mem_addr  out  32  {i_req_addr[31:2],2'b00}
o_mem_be  out  4  byte enables
o_mem_wdata  out  32  lane-replicated store data
i_mem_ack  in  1  bus completion, one cycle
i_mem_rdata  in  32  read word, valid with i_mem_ack

Behaviour:
- Reset: state IDLE; o_rvalid, o_misalign, o_bus_err, o_mem_req, o_mem_we = 0; o_mem_addr, o_mem_be, o_mem_wdata, o_rdata = 0; counter = 0.
- States: IDLE, ACCESS, ERR, DONE.
- o_stall (combinational) = (IDLE and (i_req_read or i_req_write)) or ACCESS or ERR. Low in DONE.
- IDLE + request: if misaligned (half with addr[0]=1; word with addr[1:0]!=0), go ERR with no bus access. Else capture into bus regs and go ACCESS. o_mem_req is high from the next cycle.
- Lanes: byte: be = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}. Half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}. Word: be = 1111. For reads, be is set the same way; o_mem_wdata = 0.
- ACCESS: o_mem_req held with stable addr/be/wdata/we. When i_mem_ack = 1, drop o_mem_req next edge and go DONE.
  - Read: o_rdata = (i_mem_rdata >> 8*addr[1:0]) masked to size (byte [7:0], half [15:0], word all). o_rdata is registered at the ack edge.
  - Write: o_rdata = 0.
- Timeout: counter increments each ACCESS cycle without ack. If TIMEOUT != 0 and counter reaches TIMEOUT-1 with no ack, drop o_mem_req, set o_rdata = 0, pulse o_bus_err, go DONE. An ack in that same cycle wins (normal completion, no error).
- DONE: o_rvalid = 1 for exactly one cycle (also after a timeout), stall low. The core advances at this edge. Next state is IDLE. Request inputs are ignored in DONE.
- ERR: o_misalign = 1 for one cycle, stall high, next state DONE with o_rvalid = 0 and o_rdata = 0.
- Minimum load latency: request cycle N, o_mem_req at N+1. With ack at N+1: o_rvalid/o_rdata at N+2, stall low at N+2.
- i_mem_ack in IDLE/ERR/DONE: ignored.
- Reset mid-ACCESS: next edge returns to IDLE, o_mem_req = 0. A late ack is ignored; no o_rvalid.
- o_rdata holds its value until the next completion.

Test Plan:
- Word load addr 0x100, mem returns 0xDEADBEEF, ack 1 cycle after req -> o_mem_be=1111, o_mem_addr=0x100, o_rdata=0xDEADBEEF, o_rvalid 1 cycle, stall 2 cycles.
- Byte load addr 0x103, rdata 0x80112233 -> be=1000, o_rdata=0x00000080. Half load addr 0x102 -> be=1100, o_rdata=0x00008011.
- Byte store addr 0x201, wdata 0x000000A5 -> be=0010, o_mem_wdata=0xA5A5A5A5, we=1, o_rvalid pulse, o_rdata=0. Half store addr 0x202, wdata 0x1234 -> be=1100, wdata=0x12341234.
- Word load addr 0x102 -> no o_mem_req, o_misalign pulse, stall 2 cycles, o_rvalid=0. Half load addr 0x101 -> same.
- TIMEOUT=4, no ack -> o_mem_req high 4 cycles then low, o_bus_err pulse, o_rvalid pulse, o_rdata=0. Ack on 4th cycle -> normal completion, no o_bus_err.
- i_rst asserted during ACCESS, then ack 2 cycles later -> o_mem_req low after reset edge, no o_rvalid, all outputs at reset values; i_req_read and i_req_write both high -> write performed.
